// File: rtl/alu_mul_sequencer.sv
// Multi-cycle shift-add multiply sequencer beside the EX-stage ALU.
// Owns ALUCtrl 3'b100 operations, stalls upstream for WIDTH+1 cycles, then pulses done_o.
module alu_mul_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    input  logic [2:0]       ALUCtrl_i,
    input  logic [WIDTH-1:0] data1_i,
    input  logic [WIDTH-1:0] data2_i,
    output logic             stall_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o
);
    localparam int               CNT_W    = $clog2(WIDTH + 1);
    localparam logic [2:0]       OP_MUL   = 3'b100;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mul_req;

    assign mul_req = valid_i && (ALUCtrl_i == OP_MUL);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (mul_req) begin
                    mcand_d  = data1_i;
                    mplier_d = data2_i;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CNT_W'(1);
                // Capture the accumulator including this final partial product.
                if (cnt_q == LAST_CNT) begin
                    state_d  = DONE;
                    result_d = acc_d;
                end
            end
            // The completed instruction is still on the inputs here; never re-accept it.
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign stall_o  = !rst_i && (((state_q == IDLE) && mul_req) || (state_q == RUN));
    assign done_o   = !rst_i && (state_q == DONE);
    assign result_o = result_q;

endmodule
